// File: rtl/pipe_pkg.sv
// Shared constants and slot record for the pipeline register stage.
package pipe_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int RD_W_DEF   = 5;
  localparam int CNT_W_DEF  = 16;

  // Register x0 is hardwired to zero, so it never creates a hazard.
  localparam int REG_X0 = 0;

  typedef struct packed {
    logic                  valid;
    logic                  rd_we;
    logic [RD_W_DEF-1:0]   rd_addr;
    logic [DATA_W_DEF-1:0] data;
  } slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: clear beats load, load writes the whole entry.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              d_valid,
  input  logic              d_rd_we,
  input  logic [RD_W-1:0]   d_rd_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic              q_rd_we,
  output logic [RD_W-1:0]   q_rd_addr,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_reg;
  logic              rd_we_reg;
  logic [RD_W-1:0]   rd_addr_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      valid_reg   <= 1'b0;
      rd_we_reg   <= 1'b0;
      rd_addr_reg <= '0;
      data_reg    <= '0;
    end else if (load) begin
      valid_reg   <= d_valid;
      rd_we_reg   <= d_rd_we;
      rd_addr_reg <= d_rd_addr;
      data_reg    <= d_data;
    end
  end

  assign valid     = valid_reg;
  assign q_rd_we   = rd_we_reg;
  assign q_rd_addr = rd_addr_reg;
  assign q_data    = data_reg;

endmodule

// File: rtl/pipe_reg_stage.sv
// Valid/ready pipeline register with hazard lookup and stall counter.
// Define PIPE_REG_STAGE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd_addr,
  input  logic              in_rd_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd_addr,
  output logic              out_rd_we,
  input  logic [RD_W-1:0]   query_addr,
  output logic              query_hit,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, main_we;
  logic [RD_W-1:0]   main_addr;
  logic [DATA_W-1:0] main_data;

  logic              main_load, main_d_valid, main_d_we;
  logic [RD_W-1:0]   main_d_addr;
  logic [DATA_W-1:0] main_d_data;

  logic              xfer_in, xfer_out;
  logic              query_live;
  logic              main_hit, skid_hit;
  logic [CNT_W-1:0]  stall_cnt_reg;

  assign xfer_out   = main_v && out_ready;
  assign query_live = (query_addr != RD_W'(REG_X0));
  assign main_hit   = main_v && main_we && (main_addr == query_addr);

`ifdef PIPE_REG_STAGE_SKID_EN
  logic              skid_v, skid_we;
  logic [RD_W-1:0]   skid_addr;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load, skid_d_valid, skid_v_next;
  logic              in_ready_reg;

  assign in_ready = in_ready_reg;
  assign xfer_in  = in_valid && in_ready_reg;

  // Skid only fills when main is stuck; it drains into main on the same edge out_ready frees it.
  always_comb begin
    main_load    = (!main_v && xfer_in) || xfer_out;
    main_d_valid = skid_v || xfer_in;
    main_d_we    = skid_v ? skid_we   : in_rd_we;
    main_d_addr  = skid_v ? skid_addr : in_rd_addr;
    main_d_data  = skid_v ? skid_data : in_data;
    skid_d_valid = xfer_in && main_v && !out_ready;
    skid_load    = skid_d_valid || (skid_v && out_ready);
    skid_v_next  = skid_load ? skid_d_valid : skid_v;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      in_ready_reg <= 1'b1;
    end else begin
      in_ready_reg <= !skid_v_next;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (skid_load),
    .d_valid   (skid_d_valid),
    .d_rd_we   (in_rd_we),
    .d_rd_addr (in_rd_addr),
    .d_data    (in_data),
    .valid     (skid_v),
    .q_rd_we   (skid_we),
    .q_rd_addr (skid_addr),
    .q_data    (skid_data)
  );

  assign skid_hit = skid_v && skid_we && (skid_addr == query_addr);
`else
  assign in_ready = !main_v || out_ready;
  assign xfer_in  = in_valid && in_ready;

  always_comb begin
    main_load    = xfer_in || xfer_out;
    main_d_valid = xfer_in;
    main_d_we    = in_rd_we;
    main_d_addr  = in_rd_addr;
    main_d_data  = in_data;
  end

  assign skid_hit = 1'b0;
`endif

  pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (main_load),
    .d_valid   (main_d_valid),
    .d_rd_we   (main_d_we),
    .d_rd_addr (main_d_addr),
    .d_data    (main_d_data),
    .valid     (main_v),
    .q_rd_we   (main_we),
    .q_rd_addr (main_addr),
    .q_data    (main_data)
  );

  // Counter survives flush so backpressure history is kept across pipeline kills.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (main_v && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid   = main_v;
  assign out_data    = main_data;
  assign out_rd_addr = main_addr;
  assign out_rd_we   = main_v && main_we;
  assign query_hit   = query_live && (main_hit || skid_hit);
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Directed self-checking bench for pipe_reg_stage (4-bit stall counter to reach saturation quickly).
module tb_pipe_reg_stage;

  localparam int DATA_W = 96;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, in_rd_we;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd_addr, query_addr;
  logic              out_valid, out_ready, out_rd_we, query_hit;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd_addr;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  pipe_reg_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rd_addr  (in_rd_addr),
    .in_rd_we    (in_rd_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd_addr (out_rd_addr),
    .out_rd_we   (out_rd_we),
    .query_addr  (query_addr),
    .query_hit   (query_hit),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    in_data = '0; in_rd_addr = '0; in_rd_we = 1'b0; query_addr = '0;

    // Reset
    do_reset();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_query_hit", 128'(query_hit), 128'(0));

    // Back-to-back stream, one-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      tick();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_data", 128'(out_data), 128'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 128'(out_valid), 128'(0));
    chk("stream_no_stall", 128'(stall_cnt), 128'(0));

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('hA);
    tick();
    chk("bp_first", 128'(out_data), 128'(32'hA));
    in_data = DATA_W'('hB);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_hold_valid", 128'(out_valid), 128'(1));
    chk("bp_hold_data", 128'(out_data), 128'(32'hA));
    chk("bp_stall_cnt", 128'(stall_cnt), 128'(3));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
`ifdef PIPE_REG_STAGE_SKID_EN
    chk("bp_skid_valid", 128'(out_valid), 128'(1));
    chk("bp_skid_data", 128'(out_data), 128'(32'hB));
    tick();
`endif
    chk("bp_empty", 128'(out_valid), 128'(0));
    chk("bp_cnt_kept", 128'(stall_cnt), 128'(3));

    // Flush with a beat offered in the flush cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('h11);
    tick();
`ifdef PIPE_REG_STAGE_SKID_EN
    in_data = DATA_W'('h22);
    tick();
`endif
    flush   = 1'b1;
    in_data = DATA_W'('hC);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_data", 128'(out_data), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    tick();
    chk("flush_no_c", 128'(out_valid), 128'(0));
    tick();
    chk("flush_no_c2", 128'(out_valid), 128'(0));

    // Hazard lookup
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_data    = DATA_W'('h55);
    in_rd_addr = RD_W'(5);
    in_rd_we   = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hz_out_rd_we", 128'(out_rd_we), 128'(1));
    chk("hz_out_rd_addr", 128'(out_rd_addr), 128'(5));
    query_addr = RD_W'(5); #1;
    chk("hz_hit5", 128'(query_hit), 128'(1));
    query_addr = RD_W'(0); #1;
    chk("hz_hit0", 128'(query_hit), 128'(0));
    query_addr = RD_W'(6); #1;
    chk("hz_hit6", 128'(query_hit), 128'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("hz_flush_we", 128'(out_rd_we), 128'(0));
    in_valid = 1'b1;
    in_rd_we = 1'b0;
    tick();
    in_valid   = 1'b0;
    query_addr = RD_W'(5); #1;
    chk("hz_we0_valid", 128'(out_valid), 128'(1));
    chk("hz_we0_hit", 128'(query_hit), 128'(0));

    // Stall counter saturation, survives flush
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'('h77);
    tick();
    in_valid = 1'b0;
    chk("sat_start", 128'(stall_cnt), 128'(0));
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 128'(stall_cnt), 128'(14));
    for (int i = 0; i < 6; i++) tick();
    chk("sat_20", 128'(stall_cnt), 128'(15));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_cnt", 128'(stall_cnt), 128'(15));
    chk("sat_flush_valid", 128'(out_valid), 128'(0));
    tick();
    chk("sat_after", 128'(stall_cnt), 128'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
